// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// ------------------
// UART transmit framer. A single-cycle DATA_VALID strobe in IDLE captures one
// parallel word plus its frame options. The word then goes out on TX_OUT as
//   start(0), WIDTH data bits LSB-first, optional parity, stop(1).
// Each bit is held for P CLK cycles, where P is the prescale captured with the
// word (a prescale of 0 is treated as 1).
//
// Ports
//   CLK         TX domain clock
//   RST         synchronous active-low reset, sampled on posedge CLK
//   P_DATA      parallel word, sampled when DATA_VALID=1 in IDLE
//   DATA_VALID  one-cycle strobe; ignored while a frame is in progress
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   prescale    CLK cycles per serial bit (1..63, 0 -> 1)
//   TX_OUT      serial line, registered, idles high
//   Busy        registered, high for exactly P*(2+WIDTH+PAR_EN) cycles per frame
module uart_tx_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [5:0]       prescale,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;     // captured word, frozen for the whole frame
  logic [BCW-1:0]   bit_cnt;    // index of the data bit currently on the line
  logic [5:0]       edge_cnt;   // cycles elapsed within the current bit, 0..P-1
  logic [5:0]       presc_q;    // captured P, never 0
  logic             par_en_q;
  logic             par_bit;    // parity value precomputed at capture time
  logic             bit_end;

  // Last cycle of the current serial bit. presc_q is never 0, so P-1 cannot wrap.
  assign bit_end = (edge_cnt == (presc_q - 6'd1));

  // TX_OUT is always loaded with the value of the bit being entered, so the
  // line changes on the same edge as the state and no output decode is needed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      data_q   <= '0;
      bit_cnt  <= '0;
      edge_cnt <= '0;
      presc_q  <= 6'd1;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (DATA_VALID) begin
            data_q   <= P_DATA;
            par_en_q <= PAR_EN;
            // even: XOR of the data; odd: its inverse
            par_bit  <= (^P_DATA) ^ PAR_TYP;
            presc_q  <= (prescale == 6'd0) ? 6'd1 : prescale;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            TX_OUT   <= data_q[0];
            state    <= DATA;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                TX_OUT <= par_bit;
                state  <= PARITY;
              end else begin
                TX_OUT <= 1'b1;
                state  <= STOP;
              end
            end else begin
              // bit_cnt < LAST_BIT here, so the next index stays in range
              bit_cnt <= bit_cnt + BCW'(1);
              TX_OUT  <= data_q[bit_cnt + BCW'(1)];
            end
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            edge_cnt <= '0;
            TX_OUT   <= 1'b1;
            state    <= STOP;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            // Busy falls on the edge that enters IDLE; a strobe seen in the
            // first IDLE cycle starts the next frame after one idle-high cycle.
            edge_cnt <= '0;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        default: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Each frame's expected line
// waveform is built as a list of frame bits from the data/options, and every
// cycle of the frame is compared against bits[cycle / P].
module tb_uart_tx_serializer;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [5:0]   prescale = 6'd1;
  logic         TX_OUT;
  logic         Busy;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_serializer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // advance one clock and sample 1 time unit after the edge
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    DATA_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick;
      check($sformatf("%s idle tx c%0d", tag, i), TX_OUT, 1'b1);
      check($sformatf("%s idle busy c%0d", tag, i), Busy, 1'b0);
    end
  endtask

  // Send one frame and check it cycle by cycle.
  //   disturb_at >= 0 : on that frame cycle, strobe DATA_VALID with 0x3C,
  //                     prescale=16 and flipped PAR_TYP (must be ignored)
  //   abort_at   >= 0 : on that frame cycle, pulse RST low for one edge
  // Outside the disturb cycle the other inputs are scrambled every cycle.
  task automatic run_frame(input string tag, input logic [W-1:0] d,
                           input logic pe, input logic pt, input logic [5:0] ps,
                           input int disturb_at, input int abort_at);
    int p;
    int len;
    bit bits[$];
    p = (ps == 6'd0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int b = 0; b < W; b++) bits.push_back(d[b]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    len = p * bits.size();

    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
    tick;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s tx c%0d", tag, i), TX_OUT, bits[i / p]);
      check($sformatf("%s busy c%0d", tag, i), Busy, 1'b1);
      if (i == abort_at) begin
        DATA_VALID = 1'b0;
        RST = 1'b0;
        tick;
        RST = 1'b1;
        check($sformatf("%s abort tx", tag), TX_OUT, 1'b1);
        check($sformatf("%s abort busy", tag), Busy, 1'b0);
        return;
      end
      if (i == disturb_at) begin
        DATA_VALID = 1'b1;
        P_DATA     = W'(8'h3C);
        prescale   = 6'd16;
        PAR_TYP    = ~pt;
      end else begin
        DATA_VALID = 1'b0;
        P_DATA     = W'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        prescale   = 6'($urandom);
      end
      tick;
    end
    DATA_VALID = 1'b0;
    check($sformatf("%s end tx", tag), TX_OUT, 1'b1);
    check($sformatf("%s end busy", tag), Busy, 1'b0);
  endtask

  initial begin
    // reset state
    RST = 1'b0;
    tick;
    tick;
    check("reset tx", TX_OUT, 1'b1);
    check("reset busy", Busy, 1'b0);
    RST = 1'b1;
    idle(2, "post_reset");

    // even parity 0xA5, P=8 : 88 busy cycles
    run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 6'd8, -1, -1);
    idle(3, "even_a5");

    // odd parity 0x00, P=4 : 44 busy cycles, parity bit 1
    run_frame("odd_00", 8'h00, 1'b1, 1'b1, 6'd4, -1, -1);
    idle(2, "odd_00");

    // no parity 0xFF, P=1 : 10-cycle frame
    run_frame("nopar_ff", 8'hFF, 1'b0, 1'b0, 6'd1, -1, -1);
    idle(2, "nopar_ff");

    // ignored strobe / option changes mid-frame; no second frame afterwards
    run_frame("ignore", 8'h96, 1'b1, 1'b0, 6'd8, 20, -1);
    idle(30, "ignore");

    // reset during data bit 3 (frame bit 4), then a clean 0x5A frame
    run_frame("abort", 8'hC3, 1'b1, 1'b0, 6'd8, -1, 4 * 8 + 3);
    idle(1, "abort");
    run_frame("after_abort", 8'h5A, 1'b1, 1'b1, 6'd8, -1, -1);
    idle(2, "after_abort");

    // back-to-back: second strobe in the first idle cycle
    run_frame("b2b_7e", 8'h7E, 1'b0, 1'b0, 6'd2, -1, -1);
    run_frame("b2b_81", 8'h81, 1'b0, 1'b0, 6'd2, -1, -1);
    idle(2, "b2b");

    // prescale boundaries: 0 behaves as 1, and the maximum 63
    run_frame("ps0", W'($urandom), 1'b1, 1'b0, 6'd0, -1, -1);
    idle(1, "ps0");
    run_frame("ps63", W'($urandom), 1'b1, 1'b1, 6'd63, -1, -1);
    idle(1, "ps63");

    // randomized frames, random gaps (0 = back-to-back)
    for (int k = 0; k < 20; k++) begin
      run_frame($sformatf("rnd%0d", k), W'($urandom), 1'($urandom), 1'($urandom),
                6'($urandom_range(0, 6)), -1, -1);
      idle($urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
